// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate data-cache controller for the RV32I core.
// Owns the tag/valid/dirty arrays and steers the external data memory and main memory.
module cache_controller #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              data_we,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] data_block_in,
  input  logic [DATA_W-1:0] data_block_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic              tag_we;
  logic              hit;
  logic              unused_offset;

  assign unused_offset = ^cpu_req_addr[OFFSET_W-1:0];
  assign idx           = req_q.idx;
  assign hit           = valid_q[req_q.idx] && (tag_q[req_q.idx] == req_q.tag);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      req_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags carry no reset; the valid bits alone say whether a tag means anything.
  always_ff @(posedge iCLK) begin
    if (tag_we) tag_q[req_q.idx] <= req_q.tag;
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_we        = 1'b0;
    cpu_ready     = 1'b0;
    cpu_done      = 1'b0;
    cpu_rdata     = '0;
    data_we       = 1'b0;
    data_block_in = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req_valid) begin
          req_d.tag   = cpu_req_addr[ADDR_W-1:IDX_W+OFFSET_W];
          req_d.idx   = cpu_req_addr[IDX_W+OFFSET_W-1:OFFSET_W];
          req_d.we    = cpu_req_we;
          req_d.wdata = cpu_req_wdata;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          cpu_done = 1'b1;
          if (req_q.we) begin
            data_we            = 1'b1;
            data_block_in      = req_q.wdata;
            dirty_d[req_q.idx] = 1'b1;
          end else begin
            cpu_rdata = data_block_out;
          end
          state_d = IDLE;
        end else if (valid_q[req_q.idx] && dirty_q[req_q.idx]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        // Victim address comes from the stored tag, not the request's tag.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_q.idx], req_q.idx, {OFFSET_W{1'b0}}};
        mem_wdata = data_block_out;
        if (mem_ack) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req_q.tag, req_q.idx, {OFFSET_W{1'b0}}};
        if (mem_ack) begin
          data_we            = 1'b1;
          data_block_in      = mem_rdata;
          tag_we             = 1'b1;
          valid_d[req_q.idx] = 1'b1;
          dirty_d[req_q.idx] = 1'b0;
          state_d            = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset overrides everything so no strobe or array write escapes while it is held.
    if (iRST) begin
      cpu_ready = 1'b0;
      cpu_done  = 1'b0;
      data_we   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      tag_we    = 1'b0;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: models the data memory and a delayed-ack main memory.
module tb_cache_controller;
  logic        iCLK = 1'b0, iRST = 1'b1;
  logic        cpu_req_valid = 1'b0, cpu_req_we = 1'b0;
  logic [31:0] cpu_req_addr = '0, cpu_req_wdata = '0;
  logic        cpu_ready, cpu_done;
  logic [31:0] cpu_rdata;
  logic        data_we;
  logic [4:0]  idx;
  logic [31:0] data_block_in, data_block_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] dmem [32];

  int          checks = 0, failures = 0;
  int          n_mem, done_cyc, we_pulses;
  logic [31:0] rdata_s;
  logic        log_we   [4];
  logic [31:0] log_addr [4];
  logic [31:0] log_wd   [4];

  cache_controller dut (
    .iCLK(iCLK), .iRST(iRST),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .data_we(data_we), .idx(idx), .data_block_in(data_block_in),
    .data_block_out(data_block_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 iCLK = ~iCLK;

  assign data_block_out = dmem[idx];
  always @(posedge iCLK) begin
    if (iRST) for (int i = 0; i < 32; i++) dmem[i] <= '0;
    else if (data_we) dmem[idx] <= data_block_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU request; main memory acks each transaction after dly wait cycles.
  // Cycle 1 is the first cycle after the accepting edge.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int dly);
    int wcnt;
    bit in_req;
    n_mem = 0; done_cyc = -1; we_pulses = 0; rdata_s = '0; in_req = 0; wcnt = 0;
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = wd;
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(posedge iCLK); @(negedge iCLK);
      cpu_req_valid = 1'b0;
      mem_ack = 1'b0;
      if (data_we) we_pulses++;
      if (mem_req && !in_req) begin
        if (n_mem < 4) begin
          log_we[n_mem] = mem_we; log_addr[n_mem] = mem_addr; log_wd[n_mem] = mem_wdata;
        end
        n_mem++; in_req = 1; wcnt = 0;
      end
      if (in_req) begin
        if (wcnt == dly) begin mem_ack = 1'b1; mem_rdata = rd; in_req = 0; end
        else wcnt++;
      end
      if (cpu_done) begin done_cyc = cyc; rdata_s = cpu_rdata; end
    end
    mem_ack = 1'b0;
    @(posedge iCLK); @(negedge iCLK);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge iCLK);
    chk("rst_ready",   {31'b0, cpu_ready}, 32'd0);
    chk("rst_done",    {31'b0, cpu_done},  32'd0);
    chk("rst_data_we", {31'b0, data_we},   32'd0);
    chk("rst_mem_req", {31'b0, mem_req},   32'd0);
    chk("rst_mem_we",  {31'b0, mem_we},    32'd0);
    chk("rst_rdata",   cpu_rdata,          32'd0);
    chk("rst_mem_addr", mem_addr,          32'd0);
    chk("rst_mem_wdata", mem_wdata,        32'd0);
    iRST = 1'b0;
    #1;
    chk("rst_ready_rel", {31'b0, cpu_ready}, 32'd1);
    @(negedge iCLK);

    // Cold read, 3 wait cycles
    xact(1'b0, 32'h0000_0084, '0, 32'hDEAD_BEEF, 3);
    chk("cold_nmem",  n_mem,       32'd1);
    chk("cold_we",    {31'b0, log_we[0]}, 32'd0);
    chk("cold_addr",  log_addr[0], 32'h0000_0084);
    chk("cold_cyc",   done_cyc,    32'd6);
    chk("cold_rdata", rdata_s,     32'hDEAD_BEEF);
    chk("cold_valid", {31'b0, dut.valid_q[1]}, 32'd1);
    chk("cold_dirty", {31'b0, dut.dirty_q[1]}, 32'd0);

    // Read hit
    xact(1'b0, 32'h0000_0084, '0, 32'h0, 0);
    chk("hit_nmem",  n_mem,    32'd0);
    chk("hit_cyc",   done_cyc, 32'd1);
    chk("hit_rdata", rdata_s,  32'hDEAD_BEEF);

    // Write hit
    xact(1'b1, 32'h0000_0084, 32'h1234_5678, 32'h0, 0);
    chk("wh_nmem",  n_mem,     32'd0);
    chk("wh_cyc",   done_cyc,  32'd1);
    chk("wh_we",    we_pulses, 32'd1);
    chk("wh_dirty", {31'b0, dut.dirty_q[1]}, 32'd1);
    chk("wh_dmem",  dmem[1],   32'h1234_5678);

    // Dirty eviction: same index, new tag
    xact(1'b0, 32'h0000_1084, '0, 32'hCAFE_0001, 1);
    chk("ev_nmem",   n_mem,       32'd2);
    chk("ev_wb_we",  {31'b0, log_we[0]}, 32'd1);
    chk("ev_wb_addr", log_addr[0], 32'h0000_0084);
    chk("ev_wb_data", log_wd[0],   32'h1234_5678);
    chk("ev_rf_we",  {31'b0, log_we[1]}, 32'd0);
    chk("ev_rf_addr", log_addr[1], 32'h0000_1084);
    chk("ev_cyc",    done_cyc,    32'd6);
    chk("ev_rdata",  rdata_s,     32'hCAFE_0001);
    chk("ev_dirty",  {31'b0, dut.dirty_q[1]}, 32'd0);

    // Store miss on a clean line, ack in the first mem_req cycle
    xact(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'h1111_1111, 0);
    chk("sm_nmem",  n_mem,       32'd1);
    chk("sm_we",    {31'b0, log_we[0]}, 32'd0);
    chk("sm_addr",  log_addr[0], 32'h0000_0010);
    chk("sm_cyc",   done_cyc,    32'd3);
    chk("sm_pulse", we_pulses,   32'd1);
    chk("sm_dirty", {31'b0, dut.dirty_q[4]}, 32'd1);
    chk("sm_dmem",  dmem[4],     32'hA5A5_A5A5);

    // Spurious mem_ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    @(posedge iCLK); @(negedge iCLK);
    mem_ack = 1'b0;
    chk("sp_ready",   {31'b0, cpu_ready}, 32'd1);
    chk("sp_mem_req", {31'b0, mem_req},   32'd0);
    chk("sp_done",    {31'b0, cpu_done},  32'd0);

    // Request strobe during COMPARE must not be accepted
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0010;
    @(posedge iCLK); @(negedge iCLK);
    cpu_req_we = 1'b1; cpu_req_addr = 32'h0000_0084; cpu_req_wdata = 32'hBAD0_BAD0;
    chk("pc_done",  {31'b0, cpu_done},  32'd1);
    chk("pc_rdata", cpu_rdata,          32'hA5A5_A5A5);
    chk("pc_ready", {31'b0, cpu_ready}, 32'd0);
    @(posedge iCLK); @(negedge iCLK);
    cpu_req_valid = 1'b0;
    chk("pc_idle",    {31'b0, cpu_ready}, 32'd1);
    chk("pc_nodone",  {31'b0, cpu_done},  32'd0);
    chk("pc_dmem",    dmem[1],            32'hCAFE_0001);

    // Reset while waiting for the refill ack
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0200;
    @(posedge iCLK); @(negedge iCLK);
    cpu_req_valid = 1'b0;
    @(posedge iCLK); @(negedge iCLK);
    chk("ra_req",  {31'b0, mem_req}, 32'd1);
    chk("ra_addr", mem_addr,         32'h0000_0200);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    #1 iRST = 1'b1;
    #1;
    chk("ra_req_drop", {31'b0, mem_req}, 32'd0);
    chk("ra_data_we",  {31'b0, data_we}, 32'd0);
    @(posedge iCLK); @(negedge iCLK);
    mem_ack = 1'b0;
    iRST = 1'b0;
    #1;
    chk("ra_ready", {31'b0, cpu_ready}, 32'd1);
    chk("ra_valid", {31'b0, dut.valid_q[0]}, 32'd0);
    @(negedge iCLK);
    xact(1'b0, 32'h0000_0200, '0, 32'h5555_5555, 0);
    chk("ra_re_nmem",  n_mem,       32'd1);
    chk("ra_re_addr",  log_addr[0], 32'h0000_0200);
    chk("ra_re_cyc",   done_cyc,    32'd3);
    chk("ra_re_rdata", rdata_s,     32'h5555_5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
